// File: rtl/fpu_mem_arbiter.sv
// fpu_mem_arbiter
//   Shares the single FPU memory port between three burst requesters
//   (0 = host config/mapped, 1 = column-fetch reads, 2 = result writeback).
//   A round-robin pick is made in IDLE. The winner's burst is then run beat by beat.
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     req/req_we             per-requester level request and direction (1 = write)
//     req_addr/req_len       per-requester burst start byte address and length in beats
//     req_wdata              per-requester write data for the owner's current beat
//     gnt/beat/done          per-requester one-cycle strobes, only the owner's bit is set
//     busy                   FSM not in IDLE
//     mem_req/mem_we/mem_addr/mem_wdata/mem_ack   beat-level memory handshake
module fpu_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             req,
  input  logic [2:0]             req_we,
  input  logic [2:0][ADDR_W-1:0] req_addr,
  input  logic [2:0][LEN_W-1:0]  req_len,
  input  logic [2:0][DATA_W-1:0] req_wdata,
  output logic [2:0]             gnt,
  output logic [2:0]             beat,
  output logic [2:0]             done,
  output logic                   busy,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t           state;
  logic [1:0]       owner, last_owner;
  logic [LEN_W-1:0] len_r, cnt;
  logic             zlen;   // zero-length burst: DONE lasts two cycles so done trails gnt
  logic [1:0]       c0, c1, c2, win;
  logic [2:0]       own_oh;
  logic             last_beat;

  // Rotating priority: scan last_owner+1, +2, +3 (mod 3).
  always_comb begin
    c0 = 2'd0; c1 = 2'd1; c2 = 2'd2;
    case (last_owner)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (req[c0])      win = c0;
    else if (req[c1]) win = c1;
    else              win = c2;
  end

  assign own_oh    = 3'b001 << owner;
  assign last_beat = (cnt == len_r - 1'b1);
  assign busy      = (state != IDLE);
  assign beat      = (state == XFER && mem_ack) ? own_oh : 3'b000;
  assign mem_wdata = mem_req ? req_wdata[owner] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 2'd0;
      last_owner <= 2'd2;
      len_r      <= '0;
      cnt        <= '0;
      zlen       <= 1'b0;
      gnt        <= 3'b000;
      done       <= 3'b000;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      gnt  <= 3'b000;
      done <= 3'b000;
      case (state)
        IDLE: begin
          if (|req) begin
            owner <= win;
            len_r <= req_len[win];
            cnt   <= '0;
            gnt   <= 3'b001 << win;
            if (req_len[win] != '0) begin
              state    <= XFER;
              mem_req  <= 1'b1;
              mem_we   <= req_we[win];
              mem_addr <= req_addr[win];
            end else begin
              state <= DONE;
              zlen  <= 1'b1;
            end
          end
        end
        XFER: begin
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              state    <= DONE;
              done     <= own_oh;
              mem_req  <= 1'b0;
              mem_we   <= 1'b0;
              mem_addr <= '0;
            end else begin
              mem_addr <= mem_addr + STEP;  // wraps mod 2^ADDR_W
            end
          end
        end
        DONE: begin
          if (zlen) begin
            zlen <= 1'b0;
            done <= own_oh;
          end else begin
            last_owner <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mem_arbiter.sv
module tb_fpu_mem_arbiter;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       req = '0, req_we = '0;
  logic [2:0][31:0] req_addr = '0;
  logic [2:0][9:0]  req_len = '0;
  logic [2:0][31:0] req_wdata = '0;
  logic [2:0]       gnt, beat, done;
  logic             busy, mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0]      mem_addr, mem_wdata;

  int n_tests = 0, n_fail = 0;

  typedef struct {int who; logic [31:0] addr; logic we; logic [31:0] wdata;} exp_beat_t;
  exp_beat_t beat_q[$];
  int        gnt_q[$];
  int        done_q[$];

  always #5 clk = ~clk;

  fpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .beat(beat), .done(done),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack)
  );

  function automatic logic [2:0] oh(int i);
    return (i < 0) ? 3'b000 : 3'(1 << i);
  endfunction

  // One cycle later, 1 time unit past the edge: time to drive this cycle's inputs.
  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic exp_beat_t pop_beat();
    exp_beat_t e;
    if (beat_q.size() != 0) e = beat_q.pop_front();
    else begin e.who = -1; e.addr = '0; e.we = 1'b0; e.wdata = '0; end
    return e;
  endfunction

  function automatic int pop_int(inout int q[$]);
    return (q.size() != 0) ? q.pop_front() : -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    n_tests++;
    if ({gnt, beat, done, busy, mem_req, mem_we} !== 12'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got gnt=%b beat=%b done=%b busy=%b mem_req=%b addr=%h want all 0",
               gnt, beat, done, busy, mem_req, mem_addr);
    end
    #3 rst_n = 1'b1;
    step(); #1;
    n_tests++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle got busy=%b mem_req=%b want 0 0", busy, mem_req);
    end
  endtask

  // Three requesters held high; grants must rotate 0,1,2,0,1,2.
  task automatic test_rotation();
    exp_beat_t eb; int e, g = 0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i] = 32'h100 * (i + 1); req_len[i] = 10'd1; req_we[i] = 1'b0;
    end
    mem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      gnt_q.push_back(k % 3); done_q.push_back(k % 3);
      beat_q.push_back('{k % 3, 32'h100 * ((k % 3) + 1), 1'b0, 32'h0});
    end
    req = 3'b111;
    for (int c = 1; c <= 20; c++) begin
      step(); #1;
      if (gnt !== 3'b000) begin
        e = pop_int(gnt_q); g++; n_tests++;
        if (gnt !== oh(e)) begin n_fail++; $display("FAIL rot_gnt cyc %0d got %b want %b", c, gnt, oh(e)); end
      end
      if (beat !== 3'b000) begin
        eb = pop_beat(); n_tests++;
        if (beat !== oh(eb.who) || mem_addr !== eb.addr) begin
          n_fail++; $display("FAIL rot_beat cyc %0d got beat=%b addr=%h want beat=%b addr=%h",
                             c, beat, mem_addr, oh(eb.who), eb.addr);
        end
      end
      if (done !== 3'b000) begin
        e = pop_int(done_q); n_tests++;
        if (done !== oh(e)) begin n_fail++; $display("FAIL rot_done cyc %0d got %b want %b", c, done, oh(e)); end
      end
      if (g == 6) req = 3'b000;
    end
    n_tests++;
    if (gnt_q.size() != 0 || done_q.size() != 0 || beat_q.size() != 0) begin
      n_fail++; $display("FAIL rot_left got %0d/%0d/%0d pending want 0/0/0", gnt_q.size(), done_q.size(), beat_q.size());
    end
  endtask

  task automatic test_single_burst();
    exp_beat_t eb; int nb = 0;
    req_addr[1] = 32'h1000; req_len[1] = 10'd4; req_we[1] = 1'b0; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) beat_q.push_back('{1, 32'h1000 + 32'(4 * i), 1'b0, 32'h0});
    req = 3'b010;
    for (int c = 1; c <= 7; c++) begin
      step(); #1;
      n_tests++;
      if (gnt !== (c == 1 ? 3'b010 : 3'b000) || done !== (c == 5 ? 3'b010 : 3'b000) || mem_req !== (c <= 4)) begin
        n_fail++; $display("FAIL single_ctrl cyc %0d got gnt=%b done=%b mem_req=%b want gnt=%b done=%b mem_req=%b",
                           c, gnt, done, mem_req, (c == 1 ? 3'b010 : 3'b000), (c == 5 ? 3'b010 : 3'b000), (c <= 4));
      end
      if (beat !== 3'b000) begin
        eb = pop_beat(); nb++; n_tests++;
        if (beat !== oh(eb.who) || mem_addr !== eb.addr || mem_we !== eb.we) begin
          n_fail++; $display("FAIL single_beat cyc %0d got beat=%b addr=%h we=%b want beat=%b addr=%h we=%b",
                             c, beat, mem_addr, mem_we, oh(eb.who), eb.addr, eb.we);
        end
      end
      if (c == 1) req = 3'b000;
    end
    n_tests++;
    if (nb != 4 || beat_q.size() != 0) begin
      n_fail++; $display("FAIL single_count got %0d beats want 4", nb);
    end
  endtask

  // Write burst with two wait cycles before every ack; mem_* must hold.
  task automatic test_wait_states();
    exp_beat_t eb; int nb = 0;
    req_addr[2] = 32'h3000; req_len[2] = 10'd3; req_we[2] = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) beat_q.push_back('{2, 32'h3000 + 32'(4 * i), 1'b1, 32'hA000_0000 + 32'(i)});
    req = 3'b100;
    for (int c = 1; c <= 11; c++) begin
      step();
      mem_ack = (c % 3 == 0);
      req_wdata[2] = 32'hA000_0000 + 32'((c - 1) / 3);
      #1;
      if (c <= 9) begin
        n_tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h3000 + 32'(4 * ((c - 1) / 3))
            || mem_wdata !== 32'hA000_0000 + 32'((c - 1) / 3)) begin
          n_fail++; $display("FAIL wait_hold cyc %0d got req=%b we=%b addr=%h wd=%h want 1 1 %h %h", c, mem_req, mem_we,
                             mem_addr, mem_wdata, 32'h3000 + 32'(4 * ((c - 1) / 3)), 32'hA000_0000 + 32'((c - 1) / 3));
        end
      end
      if (beat !== 3'b000) begin
        eb = pop_beat(); nb++; n_tests++;
        if (beat !== oh(eb.who) || mem_addr !== eb.addr || mem_we !== eb.we || mem_wdata !== eb.wdata) begin
          n_fail++; $display("FAIL wait_beat cyc %0d got beat=%b addr=%h wd=%h want beat=%b addr=%h wd=%h",
                             c, beat, mem_addr, mem_wdata, oh(eb.who), eb.addr, eb.wdata);
        end
      end
      n_tests++;
      if (done !== (c == 10 ? 3'b100 : 3'b000)) begin
        n_fail++; $display("FAIL wait_done cyc %0d got %b want %b", c, done, (c == 10 ? 3'b100 : 3'b000));
      end
      if (c == 1) req = 3'b000;
      if (c == 2) req_addr[2] = 32'hDEAD_0000;  // must be ignored after latch
    end
    mem_ack = 1'b0;
    n_tests++;
    if (nb != 3 || beat_q.size() != 0) begin
      n_fail++; $display("FAIL wait_count got %0d beats want 3", nb);
    end
  endtask

  task automatic test_zero_len();
    req_len[0] = 10'd0; req_addr[0] = 32'h4000; mem_ack = 1'b1;
    req = 3'b001;
    for (int c = 1; c <= 4; c++) begin
      step(); #1;
      n_tests++;
      if (gnt !== (c == 1 ? 3'b001 : 3'b000) || done !== (c == 2 ? 3'b001 : 3'b000)
          || mem_req !== 1'b0 || beat !== 3'b000 || busy !== (c <= 2)) begin
        n_fail++; $display("FAIL zlen cyc %0d got gnt=%b done=%b mem_req=%b beat=%b busy=%b want gnt=%b done=%b 0 000 %b",
                           c, gnt, done, mem_req, beat, busy, (c == 1 ? 3'b001 : 3'b000), (c == 2 ? 3'b001 : 3'b000), (c <= 2));
      end
      if (c == 1) req = 3'b000;
    end
  endtask

  task automatic test_addr_wrap();
    exp_beat_t eb; int nb = 0;
    req_addr[1] = 32'hFFFF_FFF8; req_len[1] = 10'd3; req_we[1] = 1'b0; mem_ack = 1'b1;
    beat_q.push_back('{1, 32'hFFFF_FFF8, 1'b0, 32'h0});
    beat_q.push_back('{1, 32'hFFFF_FFFC, 1'b0, 32'h0});
    beat_q.push_back('{1, 32'h0000_0000, 1'b0, 32'h0});
    req = 3'b010;
    for (int c = 1; c <= 6; c++) begin
      step(); #1;
      if (beat !== 3'b000) begin
        eb = pop_beat(); nb++; n_tests++;
        if (beat !== oh(eb.who) || mem_addr !== eb.addr) begin
          n_fail++; $display("FAIL wrap_beat cyc %0d got beat=%b addr=%h want beat=%b addr=%h",
                             c, beat, mem_addr, oh(eb.who), eb.addr);
        end
      end
      n_tests++;
      if (done !== (c == 4 ? 3'b010 : 3'b000)) begin
        n_fail++; $display("FAIL wrap_done cyc %0d got %b want %b", c, done, (c == 4 ? 3'b010 : 3'b000));
      end
      if (c == 1) req = 3'b000;
    end
    n_tests++;
    if (nb != 3) begin n_fail++; $display("FAIL wrap_count got %0d beats want 3", nb); end
  endtask

  // Abort mid-burst; last_owner is 1 before this, so only a reset restores 1's priority over 2.
  task automatic test_reset_mid();
    exp_beat_t eb; int e;
    req_addr[1] = 32'h2000; req_len[1] = 10'd5; req_we[1] = 1'b0; mem_ack = 1'b1;
    beat_q.push_back('{1, 32'h2000, 1'b0, 32'h0});
    beat_q.push_back('{1, 32'h2004, 1'b0, 32'h0});
    req = 3'b010;
    for (int c = 1; c <= 2; c++) begin
      step(); #1;
      if (c == 1) req = 3'b000;
      eb = pop_beat(); n_tests++;
      if (beat !== oh(eb.who) || mem_addr !== eb.addr) begin
        n_fail++; $display("FAIL rstmid_beat cyc %0d got beat=%b addr=%h want beat=%b addr=%h",
                           c, beat, mem_addr, oh(eb.who), eb.addr);
      end
    end
    rst_n = 1'b0; #1;
    n_tests++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || {gnt, beat, done} !== 9'h0) begin
      n_fail++; $display("FAIL rstmid_abort got mem_req=%b busy=%b gnt=%b beat=%b done=%b want all 0",
                         mem_req, busy, gnt, beat, done);
    end
    req_len[1] = 10'd1; req_len[2] = 10'd1; req_addr[1] = 32'h5000; req_addr[2] = 32'h6000; req_we[2] = 1'b0;
    gnt_q.push_back(1); gnt_q.push_back(2); done_q.push_back(1); done_q.push_back(2);
    beat_q.push_back('{1, 32'h5000, 1'b0, 32'h0});
    beat_q.push_back('{2, 32'h6000, 1'b0, 32'h0});
    req = 3'b110;
    #2 rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step(); #1;
      if (gnt !== 3'b000) begin
        e = pop_int(gnt_q); n_tests++;
        if (gnt !== oh(e)) begin n_fail++; $display("FAIL rstmid_gnt cyc %0d got %b want %b", c, gnt, oh(e)); end
        req = req & ~gnt;
      end
      if (beat !== 3'b000) begin
        eb = pop_beat(); n_tests++;
        if (beat !== oh(eb.who) || mem_addr !== eb.addr) begin
          n_fail++; $display("FAIL rstmid_beat2 cyc %0d got beat=%b addr=%h want beat=%b addr=%h",
                             c, beat, mem_addr, oh(eb.who), eb.addr);
        end
      end
      if (done !== 3'b000) begin
        e = pop_int(done_q); n_tests++;
        if (done !== oh(e)) begin n_fail++; $display("FAIL rstmid_done cyc %0d got %b want %b", c, done, oh(e)); end
      end
    end
    n_tests++;
    if (gnt_q.size() != 0 || done_q.size() != 0 || beat_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_left got %0d/%0d/%0d pending want 0/0/0", gnt_q.size(), done_q.size(), beat_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single_burst();
    test_wait_states();
    test_zero_len();
    test_addr_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
